uart_fb_loader: RTL and testbench
=================================

# uart_fb_loader

Upstream loader for the VGA frame buffer: takes bytes from the UART receive path, parses a small command packet and writes 6-bit NES palette indices into `vga_fb` through its PPU-side write port. It lets a host PC stream full or partial 256x240 frames into the display path, in place of the on-chip test-pattern generator. It runs in the `ppu_clk` domain alongside `uart_port`.

## Interface
- `HEADER`, default 8'hA5: packet sync byte.
- `TIMEOUT_CYCLES`, default 1048576: idle cycles allowed mid-packet before abort; 24-bit counter.
- `clk`  in  1  PPU-domain clock (`ppu_clk`).
- `rst`  in  1  asynchronous, active-high reset.
- `rx_valid`  in  1  received byte available.
- `rx_data`  in  8  received byte.
- `rx_ack`  out  1  one-cycle pulse; consumes the byte shown on `rx_data`.
- `ppu_ptr_x`  out  8  frame-buffer write column, 0..255.
- `ppu_ptr_y`  out  8  frame-buffer write row, 0..239.
- `ppu_DI`  out  6  palette index, equal to `rx_data[5:0]`.
- `fb_we`  out  1  one-cycle write strobe to `vga_fb` CS.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse at the end of a packet.
- `err`  out  1  one-cycle pulse on packet reject or timeout.
- `tx_data`  out  8  acknowledge byte. Exists only with `LOADER_ACK_EN`.
- `tx_valid`  out  1  acknowledge byte pending. Exists only with `LOADER_ACK_EN`.
- `tx_ready`  in  1  UART TX accepts the byte. Exists only with `LOADER_ACK_EN`.

## Operation
- Packet format, in order: `HEADER`, X0, Y0, CNT_HI, CNT_LO, then CNT pixel bytes. Only `[5:0]` of each pixel byte is used.
- States:
  - IDLE → HDR when `HEADER` is received. Any other byte is acked and discarded.
  - HDR → GETX → GETY → CNTH → CNTL, consuming one byte per state.
  - CNTL exit depends on the packet:
    - CNT==0: go to FIN.
    - Y0≥240: go to DRAIN and pulse `err`.
    - Otherwise: go to PIX.
  - PIX: for each byte, write at (x,y), then advance.
  - DRAIN: ack and discard CNT bytes without writing.
  - FIN: pulse `done` (or `err` if the packet came from DRAIN), then return to IDLE. With `LOADER_ACK_EN`, FIN first waits in ACK for the TX handshake.
- Pointer advance in PIX:
  - x increments; on x==255, x wraps to 0 and y increments.
  - On y==239 with x==255, y wraps to 0.
  - CNT > 61440 therefore overwrites from the top. This is legal.
- Remaining count is a 16-bit down-counter. The last pixel is the one written when the counter reaches 0.
- Timeout: a counter runs in every state except IDLE/FIN/ACK and clears on each `rx_ack`. At `TIMEOUT_CYCLES` it pulses `err`, sets `busy`=0 and returns to IDLE. No partial-pixel write occurs.

## Timing
- Reset values: `rx_ack`, `fb_we`, `busy`, `done`, `err`, `tx_valid` = 0; `ppu_ptr_x`, `ppu_ptr_y`, `ppu_DI` = 0; `tx_data` = 0; state = IDLE.
- `rx_ack` is combinational from `rx_valid` in every byte-consuming state, so at most one byte is consumed per clock. `rx_data` is sampled on the same edge.
- Pixel write latency: `fb_we`, `ppu_ptr_x/y` and `ppu_DI` are registered. They are valid the cycle after the `rx_ack` cycle, and `fb_we` is high for exactly one cycle. Back-to-back bytes give back-to-back writes.
- `done` and `err` are registered single-cycle pulses, asserted the cycle after the last byte is consumed.
- If `rx_valid` arrives in the FIN or ACK cycle, it is not acked until IDLE.
- Reset mid-packet drops the packet immediately. A pending `fb_we` is not issued.

## Configuration
- `LOADER_ACK_EN` defined:
  - The ACK state is added and the `tx_*` ports exist.
  - In ACK, `tx_data` = 8'h5A for success or 8'hEE for reject/timeout, and `tx_valid` is held until a cycle with `tx_ready`=1.
  - On a timeout, ACK is entered instead of going straight to IDLE.
  - No timeout applies in ACK.
- `LOADER_ACK_EN` undefined: no `tx_*` ports, no ACK state; FIN goes directly to IDLE.

## Test plan
- Reset, then A5 10 05 00 03 27 14 01 → three `fb_we` pulses at (16,5)=27, (17,5)=14, (18,5)=01; then one `done`, `busy`=0.
- A5 FF EF 00 02 2B 01 → writes at (255,239)=2B, then (0,0)=01 (both wraps).
- Bytes 33 A5 00 F0 00 02 11 22 → 33 discarded; packet rejected (Y0=240); `err` pulse; 11 and 22 acked with no `fb_we`; next A5 is parsed normally.
- A5 00 00 00 00 → no write; `done` one cycle after CNT_LO.
- A5 00 00 00 04 2B, then silence with `TIMEOUT_CYCLES`=100 → one write; `err` 100 cycles after the last ack; state IDLE.
- With `LOADER_ACK_EN`, valid 1-pixel packet and `tx_ready` held low for 10 cycles → `tx_valid`=1 with `tx_data`=5A until `tx_ready`; `done` pulses; `rst` asserted mid-wait clears `tx_valid` asynchronously.

Source files
------------

// File: rtl/uart_fb_loader.sv
// uart_fb_loader: parses HEADER, X0, Y0, CNT_HI, CNT_LO, then CNT pixel bytes
// from the UART receive path and writes 6-bit palette indices into vga_fb.
// Optional feature macro: LOADER_ACK_EN adds an ACK state and tx_* ports
// that return 8'h5A (success) or 8'hEE (reject/timeout) to the host.
//
// Handshake: a byte is offered while rx_valid is high and is consumed in the
// cycle rx_ack is high (rx_ack is combinational from rx_valid and state, so
// at most one byte per clock). In IDLE the header byte is only peeked; HDR
// consumes it. With LOADER_ACK_EN, tx_data is transferred in the cycle where
// tx_valid and tx_ready are both high.
module uart_fb_loader #(
  parameter logic [7:0]  HEADER         = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       rx_ack,
  output logic [7:0] ppu_ptr_x,
  output logic [7:0] ppu_ptr_y,
  output logic [5:0] ppu_DI,
  output logic       fb_we,
  output logic       busy,
  output logic       done,
  output logic       err,
`ifdef LOADER_ACK_EN
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
`endif
  output logic [3:0] dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_HDR   = 4'd1,
    S_GETX  = 4'd2,
    S_GETY  = 4'd3,
    S_CNTH  = 4'd4,
    S_CNTL  = 4'd5,
    S_PIX   = 4'd6,
    S_DRAIN = 4'd7,
    S_FIN   = 4'd8
`ifdef LOADER_ACK_EN
    , S_ACK = 4'd9
`endif
  } state_t;

  // The counter reads 0 in the cycle after a consumed byte, so firing at
  // TIMEOUT_CYCLES-2 puts err exactly TIMEOUT_CYCLES cycles after that byte.
  localparam logic [23:0] TMO_LAST = 24'(TIMEOUT_CYCLES - 32'd2);

  state_t      state;
  logic [7:0]  x;
  logic [7:0]  y;
  logic [7:0]  cnt_hi;
  logic [15:0] cnt;
  logic [23:0] tmo;
  logic        bad;
  logic        consume;
  logic        timed;

  assign dbg_state = state;
  assign busy      = (state != S_IDLE);
  assign rx_ack    = rx_valid & consume & ~rst;

  // Which states take a byte this cycle and which states run the timeout
  always_comb begin
    consume = 1'b0;
    timed   = 1'b0;
    case (state)
      S_IDLE: consume = (rx_data != HEADER);
      S_HDR, S_GETX, S_GETY, S_CNTH, S_CNTL, S_PIX, S_DRAIN: begin
        consume = 1'b1;
        timed   = 1'b1;
      end
      default: ;
    endcase
  end

  // Packet FSM with registered write port, pulses and acknowledge byte
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      x         <= '0;
      y         <= '0;
      cnt_hi    <= '0;
      cnt       <= '0;
      tmo       <= '0;
      bad       <= 1'b0;
      fb_we     <= 1'b0;
      ppu_ptr_x <= '0;
      ppu_ptr_y <= '0;
      ppu_DI    <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
`ifdef LOADER_ACK_EN
      tx_valid  <= 1'b0;
      tx_data   <= '0;
`endif
    end else begin
      fb_we <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;

      if (!timed || rx_ack) tmo <= '0;
      else                  tmo <= tmo + 24'd1;

      if (timed && !rx_ack && tmo >= TMO_LAST) begin
        // Abort mid-packet: nothing is written for the byte that never came
        err <= 1'b1;
`ifdef LOADER_ACK_EN
        tx_valid <= 1'b1;
        tx_data  <= 8'hEE;
        state    <= S_ACK;
`else
        state    <= S_IDLE;
`endif
      end else begin
        case (state)
          S_IDLE: if (rx_valid && rx_data == HEADER) state <= S_HDR;
          S_HDR:  if (rx_ack) state <= S_GETX;
          S_GETX: if (rx_ack) begin x <= rx_data; state <= S_GETY; end
          S_GETY: if (rx_ack) begin y <= rx_data; state <= S_CNTH; end
          S_CNTH: if (rx_ack) begin cnt_hi <= rx_data; state <= S_CNTL; end
          S_CNTL: if (rx_ack) begin
            cnt <= {cnt_hi, rx_data};
            if ({cnt_hi, rx_data} == 16'd0) begin
              bad   <= 1'b0;
              done  <= 1'b1;
              state <= S_FIN;
            end else if (y >= 8'd240) begin
              bad   <= 1'b1;
              err   <= 1'b1;
              state <= S_DRAIN;
            end else begin
              bad   <= 1'b0;
              state <= S_PIX;
            end
          end
          S_PIX: if (rx_ack) begin
            fb_we     <= 1'b1;
            ppu_ptr_x <= x;
            ppu_ptr_y <= y;
            ppu_DI    <= rx_data[5:0];
            // Raster order; the last pixel of the frame wraps to the top
            if (x == 8'd255) begin
              x <= 8'd0;
              y <= (y == 8'd239) ? 8'd0 : y + 8'd1;
            end else begin
              x <= x + 8'd1;
            end
            cnt <= cnt - 16'd1;
            if (cnt == 16'd1) begin
              done  <= 1'b1;
              state <= S_FIN;
            end
          end
          S_DRAIN: if (rx_ack) begin
            cnt <= cnt - 16'd1;
            if (cnt == 16'd1) begin
              err   <= 1'b1;
              state <= S_FIN;
            end
          end
`ifdef LOADER_ACK_EN
          S_FIN: begin
            tx_valid <= 1'b1;
            tx_data  <= bad ? 8'hEE : 8'h5A;
            state    <= S_ACK;
          end
          S_ACK: if (tx_ready) begin
            tx_valid <= 1'b0;
            state    <= S_IDLE;
          end
`else
          S_FIN: state <= S_IDLE;
`endif
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_fb_loader.sv
// Directed bench for uart_fb_loader (TIMEOUT_CYCLES = 100). Define
// LOADER_ACK_EN at compile time to exercise the acknowledge path as well.
module tb_uart_fb_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ack;
  logic [7:0] ppu_ptr_x;
  logic [7:0] ppu_ptr_y;
  logic [5:0] ppu_DI;
  logic       fb_we;
  logic       busy;
  logic       done;
  logic       err;
  logic [3:0] dbg_state;
`ifdef LOADER_ACK_EN
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
`endif

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int last_ack = 0;

  logic [7:0]  pkt_q[$];
  logic [21:0] exp_q[$];
  logic [21:0] got_q[$];
  int          we_cyc_q[$];
  int          done_cnt = 0;
  int          err_cnt  = 0;

  uart_fb_loader #(.HEADER(8'hA5), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ack(rx_ack),
    .ppu_ptr_x(ppu_ptr_x), .ppu_ptr_y(ppu_ptr_y), .ppu_DI(ppu_DI), .fb_we(fb_we),
    .busy(busy), .done(done), .err(err),
`ifdef LOADER_ACK_EN
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
`endif
    .dbg_state(dbg_state)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Capture writes and pulses mid-cycle
  always @(negedge clk) begin
    if (fb_we === 1'b1) begin
      got_q.push_back({ppu_ptr_x, ppu_ptr_y, ppu_DI});
      we_cyc_q.push_back(cyc);
    end
    if (done === 1'b1) done_cnt++;
    if (err === 1'b1) err_cnt++;
  end

  // Watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  // Driver: offer one byte from a negedge, hold until consumed (bounded)
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    #1;
    while (rx_ack !== 1'b1 && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (rx_ack !== 1'b1) begin
      fails++;
      $display("FAIL rx_ack_wait byte=%h got rx_ack=%b want 1", b, rx_ack);
    end
    last_ack = cyc;
    @(posedge clk);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_all();
    foreach (pkt_q[i]) send_byte(pkt_q[i]);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
`ifdef LOADER_ACK_EN
    tx_ready = 1'b1;
`endif
    wait_cycles(3);
    #1;
    checks += 9;
    if (rx_ack !== 1'b0) begin fails++; $display("FAIL reset_rx_ack got %b want 0", rx_ack); end
    if (fb_we !== 1'b0) begin fails++; $display("FAIL reset_fb_we got %b want 0", fb_we); end
    if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
    if (err !== 1'b0) begin fails++; $display("FAIL reset_err got %b want 0", err); end
    if (ppu_ptr_x !== 8'd0) begin fails++; $display("FAIL reset_ptr_x got %0d want 0", ppu_ptr_x); end
    if (ppu_ptr_y !== 8'd0) begin fails++; $display("FAIL reset_ptr_y got %0d want 0", ppu_ptr_y); end
    if (ppu_DI !== 6'd0) begin fails++; $display("FAIL reset_DI got %h want 0", ppu_DI); end
    if (dbg_state !== 4'd0) begin fails++; $display("FAIL reset_state got %0d want 0", dbg_state); end
`ifdef LOADER_ACK_EN
    checks += 2;
    if (tx_valid !== 1'b0) begin fails++; $display("FAIL reset_tx_valid got %b want 0", tx_valid); end
    if (tx_data !== 8'h00) begin fails++; $display("FAIL reset_tx_data got %h want 00", tx_data); end
`endif
    @(negedge clk);
    rst = 1'b0;
    wait_cycles(2);
  endtask

  task automatic compare_writes(input string name);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL %s_write_count got %0d want %0d", name, got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      if (i < got_q.size()) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          fails++;
          $display("FAIL %s_write%0d got x=%0d y=%0d di=%h want x=%0d y=%0d di=%h", name, i,
                   got_q[i][21:14], got_q[i][13:6], got_q[i][5:0],
                   exp_q[i][21:14], exp_q[i][13:6], exp_q[i][5:0]);
        end
      end
    end
  endtask

  // Three pixels at (16,5), consecutive writes, one done, busy drops
  task automatic test_basic();
    int d0;
    d0 = done_cnt;
    got_q.delete(); we_cyc_q.delete();
    exp_q = '{{8'd16, 8'd5, 6'h27}, {8'd17, 8'd5, 6'h14}, {8'd18, 8'd5, 6'h01}};
    pkt_q = '{8'hA5, 8'h10, 8'h05, 8'h00, 8'h03, 8'h27, 8'h14, 8'h01};
    send_all();
    wait_cycles(5);
    compare_writes("basic");
    checks += 3;
    if (done_cnt - d0 != 1) begin fails++; $display("FAIL basic_done_count got %0d want 1", done_cnt - d0); end
    if (busy !== 1'b0) begin fails++; $display("FAIL basic_busy got %b want 0", busy); end
    if (we_cyc_q.size() == 3 && (we_cyc_q[1] != we_cyc_q[0] + 1 || we_cyc_q[2] != we_cyc_q[1] + 1)) begin
      fails++;
      $display("FAIL basic_back_to_back got cycles %0d,%0d,%0d want consecutive", we_cyc_q[0], we_cyc_q[1], we_cyc_q[2]);
    end
  endtask

  // Bottom-right corner wraps to (0,0)
  task automatic test_wrap();
    got_q.delete(); we_cyc_q.delete();
    exp_q = '{{8'd255, 8'd239, 6'h2B}, {8'd0, 8'd0, 6'h01}};
    pkt_q = '{8'hA5, 8'hFF, 8'hEF, 8'h00, 8'h02, 8'h2B, 8'h01};
    send_all();
    wait_cycles(5);
    compare_writes("wrap");
  endtask

  // Junk byte discarded, Y0=240 rejected and drained, next packet parsed
  task automatic test_reject();
    int e0;
    int d0;
    e0 = err_cnt;
    got_q.delete(); we_cyc_q.delete();
    exp_q.delete();
    pkt_q = '{8'h33, 8'hA5, 8'h00, 8'hF0, 8'h00, 8'h02};
    send_all();
    #1;
    checks++;
    if (err !== 1'b1) begin fails++; $display("FAIL reject_err_pulse got %b want 1", err); end
    pkt_q = '{8'h11, 8'h22};
    send_all();
    wait_cycles(4);
    compare_writes("reject");
    checks++;
    if (err_cnt - e0 != 2) begin fails++; $display("FAIL reject_err_count got %0d want 2", err_cnt - e0); end
    d0 = done_cnt;
    got_q.delete(); we_cyc_q.delete();
    exp_q = '{{8'd1, 8'd2, 6'h3F}};
    pkt_q = '{8'hA5, 8'h01, 8'h02, 8'h00, 8'h01, 8'h3F};
    send_all();
    wait_cycles(5);
    compare_writes("after_reject");
    checks++;
    if (done_cnt - d0 != 1) begin fails++; $display("FAIL after_reject_done got %0d want 1", done_cnt - d0); end
  endtask

  // CNT=0: no write, done the cycle after CNT_LO
  task automatic test_zero_count();
    got_q.delete(); we_cyc_q.delete();
    exp_q.delete();
    pkt_q = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00};
    send_all();
    #1;
    checks++;
    if (done !== 1'b1) begin fails++; $display("FAIL zero_done_pulse got %b want 1", done); end
    @(negedge clk); #1;
    checks++;
    if (done !== 1'b0) begin fails++; $display("FAIL zero_done_width got %b want 0", done); end
    wait_cycles(4);
    compare_writes("zero");
  endtask

  // One pixel of four, then silence: err exactly 100 cycles after last ack
  task automatic test_timeout();
    int n;
    int t;
    got_q.delete(); we_cyc_q.delete();
    exp_q = '{{8'd0, 8'd0, 6'h2B}};
    pkt_q = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h04, 8'h2B};
    send_all();
    t = last_ack;
    n = 0;
    while (err !== 1'b1 && n < 150) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (err !== 1'b1) begin
      fails++;
      $display("FAIL timeout_err got no pulse want pulse at cycle %0d", t + 100);
    end else if (cyc != t + 100) begin
      fails++;
      $display("FAIL timeout_err_cycle got %0d want %0d", cyc, t + 100);
    end
    wait_cycles(3);
    compare_writes("timeout");
    checks += 2;
    if (busy !== 1'b0) begin fails++; $display("FAIL timeout_busy got %b want 0", busy); end
    if (dbg_state !== 4'd0) begin fails++; $display("FAIL timeout_state got %0d want 0", dbg_state); end
  endtask

`ifdef LOADER_ACK_EN
  // Ack byte held while tx_ready is low; reset clears it asynchronously
  task automatic test_ack();
    int d0;
    int bad_cycles;
    d0 = done_cnt;
    tx_ready = 1'b0;
    pkt_q = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h01, 8'h05};
    send_all();
    bad_cycles = 0;
    repeat (10) begin
      @(negedge clk);
      if (tx_valid !== 1'b1 || tx_data !== 8'h5A) bad_cycles++;
    end
    checks++;
    if (bad_cycles != 0) begin fails++; $display("FAIL ack_hold got %0d bad cycles (tx_valid=%b tx_data=%h) want 0", bad_cycles, tx_valid, tx_data); end
    tx_ready = 1'b1;
    @(negedge clk);
    checks += 2;
    if (tx_valid !== 1'b0) begin fails++; $display("FAIL ack_release got %b want 0", tx_valid); end
    if (done_cnt - d0 != 1) begin fails++; $display("FAIL ack_done got %0d want 1", done_cnt - d0); end
    tx_ready = 1'b0;
    send_all();
    wait_cycles(3);
    #2;
    rst = 1'b1;
    #1;
    checks += 2;
    if (tx_valid !== 1'b0) begin fails++; $display("FAIL ack_async_rst got %b want 0", tx_valid); end
    if (dbg_state !== 4'd0) begin fails++; $display("FAIL ack_rst_state got %0d want 0", dbg_state); end
    @(negedge clk);
    rst = 1'b0;
    tx_ready = 1'b1;
    wait_cycles(2);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_reject();
    test_zero_count();
    test_timeout();
`ifdef LOADER_ACK_EN
    test_ack();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
